// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : timer_sequencer
// Description : Drives a memory-mapped interval-timer slave. Accepts a
//               configuration request, programs period and control
//               registers, services timeout interrupts (tick/tick_count),
//               and handles stop and counter-snapshot requests.
// Ports       : clk, reset            - clock, async active-high reset
//               cfg_valid/cfg_ready   - configuration handshake
//               cfg_period            - 32-bit timer period
//               cfg_continuous        - 1 = periodic, 0 = one-shot
//               stop_req, snap_req    - single-cycle request pulses
//               tmr_*                 - timer slave bus (registered outputs)
//               running, tick         - status / timeout pulse
//               tick_count            - serviced-timeout counter
//               snap_valid/snap_value - counter snapshot result
// Revision    : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_period,
    input  logic               cfg_continuous,
    input  logic               stop_req,
    input  logic               snap_req,
    output logic [2:0]         tmr_address,
    output logic               tmr_chipselect,
    output logic               tmr_write_n,
    output logic [15:0]        tmr_writedata,
    input  logic [15:0]        tmr_readdata,
    input  logic               tmr_irq,
    output logic               running,
    output logic               tick,
    output logic [COUNT_W-1:0] tick_count,
    output logic               snap_valid,
    output logic [31:0]        snap_value
);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_STOP_W = 4'd1;
    localparam logic [3:0] c_PL_W   = 4'd2;
    localparam logic [3:0] c_PH_W   = 4'd3;
    localparam logic [3:0] c_CTRL_W = 4'd4;
    localparam logic [3:0] c_RUN    = 4'd5;
    localparam logic [3:0] c_CLR    = 4'd6;
    localparam logic [3:0] c_SNAP_W = 4'd7;
    localparam logic [3:0] c_SNAP_L = 4'd8;
    localparam logic [3:0] c_SNAP_H = 4'd9;
    localparam logic [3:0] c_HALT_W = 4'd10;

    // Timer slave register map / command words
    localparam logic [2:0]  c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  c_ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  c_ADDR_PERIODH = 3'd3;
    localparam logic [2:0]  c_ADDR_SNAPL   = 3'd4;
    localparam logic [2:0]  c_ADDR_SNAPH   = 3'd5;
    localparam logic [15:0] c_CTRL_STOP    = 16'h0008;
    localparam logic [15:0] c_CTRL_START   = 16'h0005;

    logic [3:0]         r_state;
    logic [3:0]         w_state_next;
    logic [31:0]        r_period;
    logic               r_cont;
    logic               r_stop_pend;
    logic               r_snap_pend;
    logic               r_snap_hi;
    logic [15:0]        r_snap_lo;
    logic               r_tmr_cs;
    logic               r_tmr_wn;
    logic [2:0]         r_tmr_addr;
    logic [15:0]        r_tmr_data;
    logic               w_cs;
    logic               w_wn;
    logic [2:0]         w_addr;
    logic [15:0]        w_data;
    logic               r_tick;
    logic [COUNT_W-1:0] r_tick_count;
    logic               r_snap_valid;
    logic [31:0]        r_snap_value;
    logic               w_cfg_fire;
    logic               w_enter_idle;

    assign w_cfg_fire   = (r_state == c_IDLE) && cfg_valid;
    assign w_enter_idle = (r_state != c_IDLE) && (w_state_next == c_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (cfg_valid) w_state_next = c_STOP_W;
            c_STOP_W: w_state_next = c_PL_W;
            c_PL_W:   w_state_next = c_PH_W;
            c_PH_W:   w_state_next = c_CTRL_W;
            c_CTRL_W: w_state_next = c_RUN;
            c_RUN: begin
                // Interrupt beats stop, stop beats snapshot
                if (tmr_irq)          w_state_next = c_CLR;
                else if (r_stop_pend) w_state_next = c_HALT_W;
                else if (r_snap_pend) w_state_next = c_SNAP_W;
            end
            c_CLR:    w_state_next = r_cont ? c_RUN : c_IDLE;
            c_SNAP_W: w_state_next = c_SNAP_L;
            c_SNAP_L: w_state_next = c_SNAP_H;
            c_SNAP_H: w_state_next = c_RUN;
            c_HALT_W: w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus command for the state being entered. Registering it makes the
    // access visible for exactly the cycle spent in that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs   = 1'b0;
        w_wn   = 1'b1;
        w_addr = 3'd0;
        w_data = 16'h0000;
        case (w_state_next)
            c_STOP_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_CONTROL; w_data = c_CTRL_STOP;
            end
            c_PL_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_PERIODL; w_data = r_period[15:0];
            end
            c_PH_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_PERIODH; w_data = r_period[31:16];
            end
            c_CTRL_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_CONTROL;
                w_data = c_CTRL_START | {14'd0, r_cont, 1'b0};
            end
            c_CLR: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_STATUS;
            end
            c_SNAP_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_SNAPL;
            end
            c_SNAP_L: begin
                w_cs = 1'b1; w_addr = c_ADDR_SNAPL;
            end
            c_SNAP_H: begin
                w_cs = 1'b1; w_addr = c_ADDR_SNAPH;
            end
            c_HALT_W: begin
                w_cs = 1'b1; w_wn = 1'b0; w_addr = c_ADDR_CONTROL; w_data = c_CTRL_STOP;
            end
            default: begin
                w_cs = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr_cs   <= 1'b0;
            r_tmr_wn   <= 1'b1;
            r_tmr_addr <= 3'd0;
            r_tmr_data <= 16'h0000;
        end else begin
            r_tmr_cs   <= w_cs;
            r_tmr_wn   <= w_wn;
            r_tmr_addr <= w_addr;
            r_tmr_data <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Configuration capture; a zero period would never time out, so it
    // is promoted to the shortest legal period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= 32'd0;
            r_cont   <= 1'b0;
        end else if (w_cfg_fire) begin
            r_period <= (cfg_period == 32'd0) ? 32'd1 : cfg_period;
            r_cont   <= cfg_continuous;
        end
    end

    // ------------------------------------------------------------------
    // Pending request flags. Ignored in IDLE, dropped on IDLE entry and
    // when their service starts; repeat pulses simply merge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stop_pend <= 1'b0;
            r_snap_pend <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) || w_enter_idle)
                r_stop_pend <= 1'b0;
            else if ((r_state == c_RUN) && (w_state_next == c_HALT_W))
                r_stop_pend <= 1'b0;
            else if (stop_req)
                r_stop_pend <= 1'b1;

            if ((r_state == c_IDLE) || w_enter_idle)
                r_snap_pend <= 1'b0;
            else if ((r_state == c_RUN) && (w_state_next == c_SNAP_W))
                r_snap_pend <= 1'b0;
            else if (snap_req)
                r_snap_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tick generation: the timeout counts once its status clear is done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick <= (r_state == c_CLR);
            if (r_state == c_CLR)
                r_tick_count <= r_tick_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Snapshot capture. Read data lags the address by one cycle: the low
    // half is on the bus during SNAP_H, the high half during the first
    // RUN cycle after it. The low half is staged so both halves of
    // snap_value change together with the snap_valid pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_hi    <= 1'b0;
            r_snap_lo    <= 16'h0000;
            r_snap_valid <= 1'b0;
            r_snap_value <= 32'd0;
        end else begin
            r_snap_hi    <= (r_state == c_SNAP_H);
            r_snap_valid <= r_snap_hi;
            if (r_state == c_SNAP_H)
                r_snap_lo <= tmr_readdata;
            if (r_snap_hi)
                r_snap_value <= {tmr_readdata, r_snap_lo};
        end
    end

    assign cfg_ready      = (r_state == c_IDLE);
    assign running        = (r_state == c_RUN)    || (r_state == c_CLR)    ||
                            (r_state == c_SNAP_W) || (r_state == c_SNAP_L) ||
                            (r_state == c_SNAP_H);
    assign tmr_chipselect = r_tmr_cs;
    assign tmr_write_n    = r_tmr_wn;
    assign tmr_address    = r_tmr_addr;
    assign tmr_writedata  = r_tmr_data;
    assign tick           = r_tick;
    assign tick_count     = r_tick_count;
    assign snap_valid     = r_snap_valid;
    assign snap_value     = r_snap_value;

endmodule
`default_nettype wire

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of tick_count.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cfg_valid  input  1  configuration request.
REQ-005 SHALL have port cfg_ready  output  1  high only in IDLE; a transfer occurs when cfg_valid && cfg_ready.
REQ-006 SHALL have port cfg_period  input  32  timer period, captured on transfer.
REQ-007 SHALL have port cfg_continuous  input  1  1 = periodic, 0 = one-shot; captured on transfer.
REQ-008 SHALL have port stop_req  input  1  single-cycle pulse requesting stop.
REQ-009 SHALL have port snap_req  input  1  single-cycle pulse requesting a counter snapshot.
REQ-010 SHALL have port tmr_address  output  3  timer slave register address.
REQ-011 SHALL have port tmr_chipselect  output  1  timer slave select.
REQ-012 SHALL have port tmr_write_n  output  1  timer slave write strobe, active low.
REQ-013 SHALL have port tmr_writedata  output  16  timer slave write data.
REQ-014 SHALL have port tmr_readdata  input  16  timer slave read data, valid one cycle after the address is presented.
REQ-015 SHALL have port tmr_irq  input  1  timer interrupt, level, held until the status register is written.
REQ-016 SHALL have port running  output  1  high in RUN, CLR, SNAP_W, SNAP_L, SNAP_H.
REQ-017 SHALL have port tick  output  1  one-cycle pulse per serviced timeout.
REQ-018 SHALL have port tick_count  output  COUNT_W  serviced-timeout count.
REQ-019 SHALL have port snap_valid  output  1  one-cycle pulse when snap_value is updated.
REQ-020 SHALL have port snap_value  output  32  last captured counter snapshot.

Function
REQ-021 SHALL implement FSM states IDLE, STOP_W, PL_W, PH_W, CTRL_W, RUN, CLR, SNAP_W, SNAP_L, SNAP_H, HALT_W.
REQ-022 SHALL register all tmr_* outputs; when no access is in progress, chipselect=0, write_n=1, address=0, writedata=0.
REQ-023 Each write state SHALL assert chipselect=1 and write_n=0 for exactly one cycle, then advance unconditionally; slave accepts with zero wait states.
REQ-024 On a cfg transfer, SHALL move IDLE->STOP_W (addr 1, data 0x0008) ->PL_W (addr 2, data period[15:0]) ->PH_W (addr 3, data period[31:16]) ->CTRL_W (addr 1, data 0x0005 | cont<<1) ->RUN.
REQ-025 SHALL replace a captured cfg_period of 0 with 1.
REQ-026 In RUN, SHALL use priority tmr_irq > pending stop > pending snap.
REQ-027 When tmr_irq is high in RUN, SHALL go to CLR (addr 0, data 0x0000, write), then pulse tick and increment tick_count (mod 2^COUNT_W) in the cycle after CLR.
REQ-028 After CLR, SHALL return to RUN if continuous, otherwise to IDLE.
REQ-029 SHALL latch stop_req in any non-IDLE state and service it from RUN via HALT_W (addr 1, data 0x0008) ->IDLE; stop_req in IDLE SHALL be ignored.
REQ-030 SHALL latch snap_req in any state except IDLE and service it from RUN: SNAP_W (addr 4 write, data 0) ->SNAP_L (addr 4 read: chipselect=1, write_n=1) ->SNAP_H (addr 5 read; capture readdata into snap_value[15:0]) ->RUN, capturing readdata into snap_value[31:16] and pulsing snap_valid on the RUN entry cycle.
REQ-031 A latched request SHALL be cleared when its service begins; a repeat pulse while pending SHALL merge.
REQ-032 SHALL defer tmr_irq asserting during a snapshot sequence and service it on return to RUN.
REQ-033 Entering IDLE SHALL clear pending stop and snap; tick_count SHALL hold until reset.

Reset
REQ-034 On reset assertion, SHALL immediately force state IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, running=0, tick=0, tick_count=0, snap_valid=0, snap_value=0, pending flags=0; cfg_ready=1 once reset deasserts.
REQ-035 Reset mid-sequence SHALL abort without completing any further slave access.

Verification
REQ-036 cfg period=0x002DC6BF, cont=1 -> writes (1,0x0008),(2,0xC6BF),(3,0x002D),(1,0x0007) on 4 consecutive cycles, running=1.
REQ-037 Continuous run, tmr_irq raised 3 times -> 3 status writes (addr 0), tick_count=3, remains RUN.
REQ-038 One-shot cfg, one tmr_irq -> single CLR write, tick=1, returns IDLE with cfg_ready=1.
REQ-039 snap_req in RUN with readdata 0x1234 then 0x00AB -> snap_value=0x00AB1234, snap_valid one cycle; tmr_irq raised during SNAP_L is serviced immediately after.
REQ-040 cfg_period=0 -> PL_W writes 0x0001; stop_req during PH_W -> CTRL_W completes, then HALT_W writes 0x0008, IDLE.
REQ-041 reset asserted in PL_W -> tmr_chipselect=0 asynchronously, no further writes, tick_count=0.
